// File: rtl/matvec_pkg.sv
// rtl/matvec_pkg.sv - shared types and constants for the matrix/vector byte loader
//
// Purpose: element width, matrix dimension, frame header codes, the float word
// type and the loader state encoding used by the loader, its interface and the
// word assembler.
package matvec_pkg;

  localparam int WORD_W = 32;
  localparam int N      = 4;

  localparam logic [7:0] HDR_FULL = 8'hA5;
  localparam logic [7:0] HDR_VEC  = 8'h5A;

  // Payload sizes in bytes: N*N matrix words, then N vector words.
  localparam int MAT_BYTES = N * N * WORD_W / 8;
  localparam int VEC_BYTES = N * WORD_W / 8;

  typedef logic [WORD_W-1:0] float_word_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_MAT = 2'd1,
    LOAD_VEC = 2'd2,
    PRESENT  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/matrix_vector_loader_if.sv
// rtl/matrix_vector_loader_if.sv - byte-in / frame-out bus of the matrix/vector loader
//
// Purpose: groups the input byte stream and the parallel frame output.
// Ports (signals):
//   i_byte/i_valid/i_ready : incoming byte stream, accepted on i_valid & i_ready
//   o_mat/o_vec/o_valid/o_ready : assembled frame, row-major matrix (r*N+c) and vector
//   o_frame_err : one-cycle pulse on bad header or inter-byte timeout
// Modports: master = byte source / frame sink, slave = loader.
interface matrix_vector_loader_if;
  import matvec_pkg::*;

  logic [7:0]               i_byte;
  logic                     i_valid;
  logic                     i_ready;
  float_word_t [N*N-1:0]    o_mat;
  float_word_t [N-1:0]      o_vec;
  logic                     o_valid;
  logic                     o_ready;
  logic                     o_frame_err;

  modport master (
    output i_byte, i_valid, o_ready,
    input  i_ready, o_mat, o_vec, o_valid, o_frame_err
  );

  modport slave (
    input  i_byte, i_valid, o_ready,
    output i_ready, o_mat, o_vec, o_valid, o_frame_err
  );

endinterface

// File: rtl/matvec_word_assembler.sv
// rtl/matvec_word_assembler.sv - little-endian 4-byte to float word assembler
//
// Purpose: collects bytes (first byte -> [7:0]) and emits word_done for one
// cycle together with the assembled word when the fourth byte arrives.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   clr        : discard any partial word (abort)
//   in_valid   : in_byte is consumed this cycle
//   in_byte    : stream byte
//   word_done  : combinational, high in the cycle the fourth byte is consumed
//   word       : assembled word, meaningful while word_done is high
module matvec_word_assembler
  import matvec_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        word_done,
  output float_word_t word
);

  // Only the first three bytes need storage; the fourth is taken straight
  // from the input so the word is available in the cycle it completes.
  logic [23:0] sr_q, sr_d;
  logic [1:0]  idx_q, idx_d;

  assign word = {in_byte, sr_q};

  always_comb begin
    sr_d      = sr_q;
    idx_d     = idx_q;
    word_done = 1'b0;
    if (clr) begin
      sr_d  = '0;
      idx_d = '0;
    end else if (in_valid) begin
      sr_d      = {in_byte, sr_q[23:8]};
      idx_d     = idx_q + 2'd1;
      word_done = (idx_q == 2'd3);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else begin
      sr_q  <= sr_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/matrix_vector_loader.sv
// rtl/matrix_vector_loader.sv - framed byte stream to 4x4 matrix + 4-vector loader
//
// Purpose: receives header 0xA5 + 64 matrix bytes + 16 vector bytes, assembles
// little-endian float words and presents the whole frame on a valid/ready
// handshake. Bad headers and inter-byte timeouts pulse o_frame_err.
// Optional feature: MATVEC_VECTOR_ONLY_EN - header 0x5A reloads only the vector
// once a full frame has been loaded.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : matrix_vector_loader_if.slave (byte stream in, frame out, error pulse)
// Parameters:
//   TIMEOUT_CYCLES : max cycles between accepted bytes inside a frame
module matrix_vector_loader
  import matvec_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 12000
) (
  input  logic                   clk,
  input  logic                   rst,
  matrix_vector_loader_if.slave  bus
);

  localparam int TO_W      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam int MAT_IDX_W = $clog2(N * N);
  localparam int VEC_IDX_W = $clog2(N);

  loader_state_t         state_q, state_d;
  logic [6:0]            byte_cnt_q, byte_cnt_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  float_word_t [N*N-1:0] mat_stage_q, mat_stage_d;
  float_word_t [N-1:0]   vec_stage_q, vec_stage_d;
  float_word_t [N*N-1:0] o_mat_q, o_mat_d;
  float_word_t [N-1:0]   o_vec_q, o_vec_d;
  logic                  err_q, err_d;
`ifdef MATVEC_VECTOR_ONLY_EN
  logic                  mat_loaded_q, mat_loaded_d;
  logic                  vec_only_q, vec_only_d;
`endif

  logic        accept;
  logic        in_load;
  logic        timeout;
  logic        asm_valid;
  logic        word_done;
  float_word_t word;

  assign accept    = bus.i_valid & bus.i_ready;
  assign in_load   = (state_q == LOAD_MAT) || (state_q == LOAD_VEC);
  assign timeout   = in_load && (to_cnt_q == TO_LAST);
  // A byte arriving in the timeout cycle is dropped.
  assign asm_valid = accept & in_load & ~timeout;

  assign bus.i_ready     = rst & (state_q != PRESENT);
  assign bus.o_valid     = (state_q == PRESENT);
  assign bus.o_mat       = o_mat_q;
  assign bus.o_vec       = o_vec_q;
  assign bus.o_frame_err = err_q;

  matvec_word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (timeout),
    .in_valid  (asm_valid),
    .in_byte   (bus.i_byte),
    .word_done (word_done),
    .word      (word)
  );

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    to_cnt_d    = to_cnt_q;
    mat_stage_d = mat_stage_q;
    vec_stage_d = vec_stage_q;
    o_mat_d     = o_mat_q;
    o_vec_d     = o_vec_q;
    err_d       = 1'b0;
`ifdef MATVEC_VECTOR_ONLY_EN
    mat_loaded_d = mat_loaded_q;
    vec_only_d   = vec_only_q;
`endif

    // Inter-byte timer: runs only inside a frame and saturates at the limit.
    if (in_load) begin
      if (timeout || accept) begin
        to_cnt_d = '0;
      end else if (to_cnt_q != TO_LAST) begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end else begin
      to_cnt_d = '0;
    end

    unique case (state_q)
      IDLE: begin
        byte_cnt_d = '0;
        if (accept) begin
          if (bus.i_byte == HDR_FULL) begin
            state_d = LOAD_MAT;
`ifdef MATVEC_VECTOR_ONLY_EN
            vec_only_d = 1'b0;
          end else if ((bus.i_byte == HDR_VEC) && mat_loaded_q) begin
            state_d    = LOAD_VEC;
            vec_only_d = 1'b1;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end

      LOAD_MAT: begin
        if (timeout) begin
          state_d    = IDLE;
          byte_cnt_d = '0;
          err_d      = 1'b1;
        end else if (asm_valid) begin
          byte_cnt_d = byte_cnt_q + 7'd1;
          if (word_done) begin
            mat_stage_d[byte_cnt_q[2 +: MAT_IDX_W]] = word;
          end
          if (byte_cnt_q == 7'(MAT_BYTES - 1)) begin
            state_d    = LOAD_VEC;
            byte_cnt_d = '0;
          end
        end
      end

      LOAD_VEC: begin
        if (timeout) begin
          state_d    = IDLE;
          byte_cnt_d = '0;
          err_d      = 1'b1;
        end else if (asm_valid) begin
          byte_cnt_d = byte_cnt_q + 7'd1;
          if (word_done) begin
            vec_stage_d[byte_cnt_q[2 +: VEC_IDX_W]] = word;
          end
          if (byte_cnt_q == 7'(VEC_BYTES - 1)) begin
            // Publish the frame in one step so no partial data is ever visible.
            state_d    = PRESENT;
            byte_cnt_d = '0;
            o_vec_d    = vec_stage_d;
`ifdef MATVEC_VECTOR_ONLY_EN
            // A vector-only frame keeps the last published matrix; the staging
            // buffer may hold a partially overwritten, aborted matrix.
            if (!vec_only_q) begin
              o_mat_d      = mat_stage_q;
              mat_loaded_d = 1'b1;
            end
`else
            o_mat_d = mat_stage_q;
`endif
          end
        end
      end

      PRESENT: begin
        if (bus.o_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      to_cnt_q    <= '0;
      mat_stage_q <= '0;
      vec_stage_q <= '0;
      o_mat_q     <= '0;
      o_vec_q     <= '0;
      err_q       <= 1'b0;
`ifdef MATVEC_VECTOR_ONLY_EN
      mat_loaded_q <= 1'b0;
      vec_only_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      to_cnt_q    <= to_cnt_d;
      mat_stage_q <= mat_stage_d;
      vec_stage_q <= vec_stage_d;
      o_mat_q     <= o_mat_d;
      o_vec_q     <= o_vec_d;
      err_q       <= err_d;
`ifdef MATVEC_VECTOR_ONLY_EN
      mat_loaded_q <= mat_loaded_d;
      vec_only_q   <= vec_only_d;
`endif
    end
  end

endmodule

// File: tb/tb_matrix_vector_loader.sv
// tb/tb_matrix_vector_loader.sv - directed self-checking bench for matrix_vector_loader
module tb_matrix_vector_loader;

  localparam int T = 12000;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [31:0] exp_mat [16];
  logic [31:0] exp_vec [4];

  matrix_vector_loader_if bus ();

  matrix_vector_loader #(.TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Offer one byte from a negedge and hold it until it is taken at a posedge.
  task automatic send_byte(input logic [7:0] b, input bit chk_pre);
    int n;
    @(negedge clk);
    bus.i_byte  = b;
    bus.i_valid = 1'b1;
    n = 0;
    while (!bus.i_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.i_ready) check("send_stall", 32'd0, 32'd1);
    if (chk_pre) check("pre_valid", {31'd0, bus.o_valid}, 32'd0);
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit last);
    send_byte(w[7:0], 1'b0);
    send_byte(w[15:8], 1'b0);
    send_byte(w[23:16], 1'b0);
    send_byte(w[31:24], last);
  endtask

  // with_mat = 0 sends only the vector payload after the header.
  task automatic send_frame(input logic [7:0] hdr, input bit with_mat);
    send_byte(hdr, 1'b0);
    if (with_mat) begin
      for (int i = 0; i < 16; i++) send_word(exp_mat[i], 1'b0);
    end
    for (int j = 0; j < 4; j++) send_word(exp_vec[j], j == 3);
  endtask

  task automatic check_frame(input string tag);
    @(negedge clk);
    check({tag, "_valid"}, {31'd0, bus.o_valid}, 32'd1);
    check({tag, "_irdy"}, {31'd0, bus.i_ready}, 32'd0);
    for (int i = 0; i < 16; i++) check($sformatf("%s_m%0d", tag, i), bus.o_mat[i], exp_mat[i]);
    for (int j = 0; j < 4; j++) check($sformatf("%s_v%0d", tag, j), bus.o_vec[j], exp_vec[j]);
  endtask

  initial begin
    int  n;
    bit  seen;
    errors      = 0;
    checks      = 0;
    rst         = 1'b1;
    bus.i_byte  = 8'h00;
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b0;

    // Reset state
    #3 rst = 1'b0;
    #1;
    check("rst_valid", {31'd0, bus.o_valid}, 32'd0);
    check("rst_irdy", {31'd0, bus.i_ready}, 32'd0);
    check("rst_err", {31'd0, bus.o_frame_err}, 32'd0);
    check("rst_m5", bus.o_mat[5], 32'd0);
    check("rst_v0", bus.o_vec[0], 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_irdy", {31'd0, bus.i_ready}, 32'd1);

    // 1: identity matrix, vector [1,2,3,4], o_ready high
    for (int i = 0; i < 16; i++) exp_mat[i] = (i % 5 == 0) ? 32'h3F800000 : 32'h0;
    exp_vec[0] = 32'h3F800000; exp_vec[1] = 32'h40000000;
    exp_vec[2] = 32'h40400000; exp_vec[3] = 32'h40800000;
    bus.o_ready = 1'b1;
    send_frame(8'hA5, 1'b1);
    check_frame("t1");
    @(negedge clk);
    check("t1_done_valid", {31'd0, bus.o_valid}, 32'd0);
    check("t1_done_irdy", {31'd0, bus.i_ready}, 32'd1);

    // 2: o_ready low for 20 cycles, pending extra byte must wait
    bus.o_ready = 1'b0;
    send_frame(8'hA5, 1'b1);
    bus.i_byte  = 8'h00;
    bus.i_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("t2_hold_valid", {31'd0, bus.o_valid}, 32'd1);
      check("t2_hold_irdy", {31'd0, bus.i_ready}, 32'd0);
      check("t2_hold_err", {31'd0, bus.o_frame_err}, 32'd0);
      check("t2_hold_m15", bus.o_mat[15], exp_mat[15]);
      check("t2_hold_v3", bus.o_vec[3], exp_vec[3]);
    end
    bus.o_ready = 1'b1;
    @(negedge clk);
    check("t2_hs_valid", {31'd0, bus.o_valid}, 32'd0);
    check("t2_hs_irdy", {31'd0, bus.i_ready}, 32'd1);
    check("t2_hs_err", {31'd0, bus.o_frame_err}, 32'd0);
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
    @(negedge clk);
    check("t2_extra_err", {31'd0, bus.o_frame_err}, 32'd1);

    // 3: bad header then a valid frame
    send_byte(8'h00, 1'b0);
    @(negedge clk);
    check("t3_err", {31'd0, bus.o_frame_err}, 32'd1);
    @(negedge clk);
    check("t3_err_pulse", {31'd0, bus.o_frame_err}, 32'd0);
    for (int i = 0; i < 16; i++) exp_mat[i] = 32'h41000000 + i;
    for (int j = 0; j < 4; j++) exp_vec[j] = 32'hC0000000 + j;
    send_frame(8'hA5, 1'b1);
    check_frame("t3");

    // 4: ten frame bytes then silence until the inter-byte timeout fires
    send_byte(8'hA5, 1'b0);
    for (int b = 0; b < 9; b++) send_byte(8'h77, 1'b0);
    n = 0;
    seen = 1'b0;
    while (!seen && n < T + 200) begin
      @(negedge clk);
      n++;
      if (bus.o_frame_err) seen = 1'b1;
    end
    check("t4_to_seen", {31'd0, seen}, 32'd1);
    check("t4_to_lat", n, T + 1);
    check("t4_hold_m1", bus.o_mat[1], exp_mat[1]);
    @(negedge clk);
    check("t4_err_pulse", {31'd0, bus.o_frame_err}, 32'd0);
    check("t4_irdy", {31'd0, bus.i_ready}, 32'd1);
    for (int i = 0; i < 16; i++) exp_mat[i] = 32'h12340000 | (i * 32'h0101);
    for (int j = 0; j < 4; j++) exp_vec[j] = 32'h5A5A0000 + (j << 4);
    send_frame(8'hA5, 1'b1);
    check_frame("t4");

    // 5: reset in the middle of a frame
    send_byte(8'hA5, 1'b0);
    for (int b = 0; b < 39; b++) send_byte(8'h3C, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_valid", {31'd0, bus.o_valid}, 32'd0);
    check("t5_irdy", {31'd0, bus.i_ready}, 32'd0);
    check("t5_err", {31'd0, bus.o_frame_err}, 32'd0);
    for (int i = 0; i < 16; i++) check($sformatf("t5_m%0d", i), bus.o_mat[i], 32'd0);
    for (int j = 0; j < 4; j++) check($sformatf("t5_v%0d", j), bus.o_vec[j], 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // 6a: 0x5A with no matrix loaded is a bad header in every build
    send_byte(8'h5A, 1'b0);
    @(negedge clk);
    check("t6_5a_noload_err", {31'd0, bus.o_frame_err}, 32'd1);

    for (int i = 0; i < 16; i++) exp_mat[i] = 32'hBF800000 - i;
    for (int j = 0; j < 4; j++) exp_vec[j] = 32'h3F000000 + j;
    send_frame(8'hA5, 1'b1);
    check_frame("t5");

`ifdef MATVEC_VECTOR_ONLY_EN
    // 6b: vector-only reload keeps the matrix
    for (int j = 0; j < 4; j++) exp_vec[j] = 32'h40000000;
    send_frame(8'h5A, 1'b0);
    check_frame("t6");
    @(negedge clk);
    check("t6_done_err", {31'd0, bus.o_frame_err}, 32'd0);
`else
    // 6b: without the feature 0x5A stays a bad header after a full frame
    send_byte(8'h5A, 1'b0);
    @(negedge clk);
    check("t6_5a_err", {31'd0, bus.o_frame_err}, 32'd1);
    check("t6_5a_valid", {31'd0, bus.o_valid}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
